// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer with word framing,
// a one-entry output register and valid/ready handshake.
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     serial_in,
    input  logic                     shift_en,
    input  logic                     frame_start,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         parallel_out,
    output logic                     out_valid,
    output logic                     overrun,
    output logic [$clog2(WIDTH)-1:0] bit_count
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CW-1:0]    cnt_eff;
    logic             done;

    // Next shift value, realigned count and word-completion flag
    always_comb begin
        cnt_eff = frame_start ? '0 : bit_count;
        if (MSB_FIRST) begin
            sr_next = {sr[WIDTH-2:0], serial_in};
        end else begin
            sr_next = {serial_in, sr[WIDTH-1:1]};
        end
        done = shift_en && (cnt_eff == LAST);
    end

    // Shift register and position within the current word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr        <= '0;
            bit_count <= '0;
        end else if (clear) begin
            sr        <= '0;
            bit_count <= '0;
        end else if (shift_en) begin
            sr        <= sr_next;
            bit_count <= done ? '0 : cnt_eff + CW'(1);
        end else if (frame_start) begin
            bit_count <= '0;
        end
    end

    // Output holding register, handshake and sticky overrun
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parallel_out <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
        end else if (clear) begin
            parallel_out <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
        end else if (done) begin
            parallel_out <= sr_next;
            out_valid    <= 1'b1;
            if (out_valid && !out_ready) begin
                overrun <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-in, parallel-out deserializer with word framing and a one-entry output holding register with valid/ready handshake. It samples one bit per enabled clock and assembles WIDTH-bit words, MSB-first by default. Completed words are presented on parallel_out, with sticky overrun detection when the consumer stalls. It sits at the receive end of the team's serial shift-register links, feeding parallel datapath logic.

Parameters:
WIDTH, 4, word width in bits; legal range WIDTH >= 2.
MSB_FIRST, 1, 1 = first received bit lands in parallel_out[WIDTH-1]; 0 = first received bit lands in parallel_out[0].

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous clear; same effect as reset.
serial_in  input  1  serial data bit, sampled only when shift_en=1.
shift_en  input  1  sample serial_in this cycle.
frame_start  input  1  realign: discard partial word; bit sampled this cycle (if any) becomes bit 0.
out_ready  input  1  consumer accepts parallel_out this cycle.
parallel_out  output  WIDTH  last completed word (registered).
out_valid  output  1  parallel_out holds an unconsumed word.
overrun  output  1  sticky: a completed word overwrote an unconsumed word.
bit_count  output  clog2(WIDTH)  bits of the current partial word received so far.

Behaviour:
- Reset (reset_n=0, async) or clear=1 (sync): shift register, bit_count, parallel_out, out_valid and overrun all go to 0.
- Priority per edge: reset_n > clear > frame_start > shift_en.
- Shift when shift_en=1. MSB_FIRST=1: sr <= {sr[WIDTH-2:0], serial_in}. MSB_FIRST=0: sr <= {serial_in, sr[WIDTH-1:1]}. bit_count increments.
- shift_en=0: shift register and bit_count hold. No bit is consumed.
- frame_start=1: bit_count is treated as 0 before this cycle's shift. With shift_en=1, bit_count becomes 1 and the sampled bit is bit 0 of the new word. With shift_en=0, bit_count becomes 0. The partial word is discarded and nothing is emitted. out_valid, parallel_out and overrun are unaffected.
- Word completion: shift_en=1 and effective bit_count == WIDTH-1.
  - At that same edge, parallel_out <= the fully shifted word (including this bit), out_valid <= 1, and bit_count <= 0.
  - Latency: the word is visible immediately after the edge that samples its last bit.
- Handshake:
  - out_valid stays 1 and parallel_out stays stable until an edge with out_ready=1.
  - At that edge, out_valid <= 0, unless a word completes at the same edge.
  - out_ready while out_valid=0 is ignored.
- Simultaneous events:
  - Completion with out_valid=1 and out_ready=1: the new word loads, out_valid stays 1, no overrun.
  - Completion with out_valid=1 and out_ready=0: the new word overwrites parallel_out (newest wins), out_valid stays 1, overrun <= 1.
- overrun is sticky; it is cleared only by reset_n or clear.
- Back-to-back words (shift_en held high) are supported at full rate: one word every WIDTH cycles, with no dead cycle.
- Reset or clear mid-word discards the partial word. The next sampled bit is bit 0.
- No combinational path from any input to any output.

Test Plan:
- Reset, then WIDTH=4, MSB_FIRST=1, shift_en=1, serial_in=1,0,1,1 on consecutive edges -> after the 4th edge parallel_out=4'b1011, out_valid=1, bit_count=0. Check bit_count=1,2,3 after edges 1-3.
- MSB_FIRST=0, same bits 1,0,1,1 -> parallel_out=4'b1101. Insert shift_en=0 gaps between bits -> same result; completion occurs only on the 4th enabled edge.
- out_ready=0, send 1011 then 0110 -> parallel_out=4'b0110, out_valid=1, overrun=1. Then assert out_ready one cycle -> out_valid=0 and overrun stays 1. Then clear=1 -> overrun=0.
- Hold out_ready=1 and shift_en=1 continuously for words 1011, 0110, 1111:
  - out_valid is high for exactly 1 cycle after each word's 4th edge.
  - overrun stays 0.
  - parallel_out sequence is 1011, 0110, 1111.
- Send bits 1,1, then frame_start=1 with bits 0,0,1,0 (frame_start on the first of these) -> parallel_out=4'b0010, with no emission for the discarded partial word.
- Drive reset_n=0 asynchronously (between clock edges) after 3 bits -> all outputs 0 immediately. After release, bits 1,0,0,1 -> parallel_out=4'b1001.
